mole_led_timer: RTL and testbench
=================================

// Module: mole_led_timer
// PURPOSE
// - Responder for the RNG led_index/led_request interface. Accepts light requests.
// - Lights the addressed LED for a difficulty-dependent lifetime.
// - Extinguishes an LED on a hit-clear from the switch/score logic, or on timeout.
// - Reports timeouts as a one-cycle expired mask. Sits between the RNG and the switch/score logic.
// PARAMETERS
// - NUM_LEDS    18      number of LEDs/timers; 1..32
// - TICK_DIV    50000   clk cycles per lifetime tick (1 ms at 50 MHz); >=2
// - LIFE_EASY   200     lifetime in ticks, level 0; 1..255
// - LIFE_MED    100     lifetime in ticks, level 1; 1..255
// - LIFE_HARD   50      lifetime in ticks, levels 2 and 3; 1..255
// - MAX_ACTIVE  4       max simultaneously lit LEDs; 1..NUM_LEDS
// PORTS
// - clk          in   1         system clock
// - rst          in   1         synchronous, active-high reset
// - level        in   2         difficulty, sampled only when a request is accepted
// - led_index    in   5         LED to light; valid with led_request
// - led_request  in   1         one-cycle request strobe
// - hit_clear    in   NUM_LEDS  per-LED clear (player hit); level-sensitive
// - led_on       out  NUM_LEDS  registered LED state, drives LEDR
// - expired      out  NUM_LEDS  one-cycle pulse per LED that timed out
// - req_drop     out  1         one-cycle pulse: request rejected
// - active_cnt   out  6         registered popcount of led_on
// BEHAVIOUR
// - Reset: led_on=0, expired=0, req_drop=0, active_cnt=0, all timers=0, prescaler=0.
// - Prescaler: counts 0..TICK_DIV-1 and wraps. Internal tick=1 on the cycle count==TICK_DIV-1.
// - Per-LED state: 8-bit timer[i]. LED i is lit iff led_on[i]=1.
// - Request sampled at edge N. Accepted iff all of the following hold:
//   - led_index<NUM_LEDS
//   - led_on[idx]==0
//   - active_cnt<MAX_ACTIVE
//   On accept: led_on[idx]=1 and timer[idx]=LIFE(level), visible after edge N (latency 1).
//   Otherwise req_drop=1 for exactly one cycle after edge N and no state changes.
//   A request when LED already lit never retriggers or extends its timer.
// - Hit: hit_clear[i]=1 while led_on[i]=1 -> led_on[i]=0, timer[i]=0 next cycle, expired[i]=0.
//   hit_clear on an unlit LED is ignored.
// - Tick: each lit LED with timer>1 decrements by 1.
//   A lit LED with timer==1 clears led_on[i] next cycle and pulses expired[i] that same cycle.
//   Several LEDs may expire on one tick; all of their bits pulse together.
// - Priority within one cycle, per LED:
//   - clear vs expiry on the same LED: clear wins, no expired bit.
//   - request vs expiry or clear on a lit LED: request dropped, since the LED was lit when sampled.
//   - request and hit_clear on the same unlit LED: request accepted.
// - active_cnt is the count of lit LEDs after the update; it equals popcount(led_on) every cycle.
//   MAX_ACTIVE is checked against the pre-update active_cnt, so a slot freed this cycle is usable next cycle.
// - A change of level affects only timers loaded after the change.
// - Asserting rst mid-operation clears everything within one cycle. No expired pulse is generated.
// CONFIGURATION
// - MOLE_MISS_CNT_EN defined: adds port miss_cnt out 8.
//   - Adds popcount(expired) each cycle, saturating at 255; reset value 0.
//   - Saturation is sticky until rst.
// - Undefined: miss_cnt port and its logic are absent. All other behaviour is identical.
// TESTING (bench: TICK_DIV=4, LIFE_EASY=3, LIFE_MED=2, LIFE_HARD=1, MAX_ACTIVE=2)
// - Lifetime: level=0, request idx 5.
//   -> led_on[5]=1 next cycle; expired[5] pulses 1 cycle after the 3rd tick; led_on[5]=0 with it.
// - Hit before timeout: level=1, request idx 0, assert hit_clear[0] before the 2nd tick.
//   -> led_on[0]=0 next cycle, no expired pulse, active_cnt 1->0.
// - Bad index: request idx 18 -> req_drop=1 for 1 cycle, led_on unchanged.
// - Lit LED: request idx 3 twice, 2nd while lit -> req_drop pulse; timer not reloaded (expiry time unchanged).
// - Cap: requests idx 1, 2, 7 on consecutive cycles -> idx 7 dropped; active_cnt=2.
//   Expire idx 1, then re-request idx 7 -> accepted.
// - Tie: hit_clear[4] on the same cycle as idx 4's final tick -> expired[4] stays 0.
//   With MOLE_MISS_CNT_EN, miss_cnt unchanged. Two simultaneous expiries -> miss_cnt += 2.

Source files
------------

// File: rtl/mole_led_timer_if.sv
// Request/clear/status bundle between the RNG, the LED timer bank and the switch/score logic.
// With MOLE_MISS_CNT_EN defined the bundle also carries the saturating miss counter.
interface mole_led_timer_if #(
    parameter int unsigned NUM_LEDS = 18
);
    logic [1:0]          level;
    logic [4:0]          led_index;
    logic                led_request;
    logic [NUM_LEDS-1:0] hit_clear;
    logic [NUM_LEDS-1:0] led_on;
    logic [NUM_LEDS-1:0] expired;
    logic                req_drop;
    logic [5:0]          active_cnt;
`ifdef MOLE_MISS_CNT_EN
    logic [7:0]          miss_cnt;

    modport master (
        output level, led_index, led_request, hit_clear,
        input  led_on, expired, req_drop, active_cnt, miss_cnt
    );
    modport slave (
        input  level, led_index, led_request, hit_clear,
        output led_on, expired, req_drop, active_cnt, miss_cnt
    );
`else
    modport master (
        output level, led_index, led_request, hit_clear,
        input  led_on, expired, req_drop, active_cnt
    );
    modport slave (
        input  level, led_index, led_request, hit_clear,
        output led_on, expired, req_drop, active_cnt
    );
`endif
endinterface

// File: rtl/mole_led_timer.sv
// Per-LED lifetime timers for the whack-a-mole game: lights requested LEDs, clears on hit or timeout.
// Optional MOLE_MISS_CNT_EN adds a saturating count of timed-out LEDs (bus.miss_cnt).
module mole_led_timer #(
    parameter int unsigned NUM_LEDS   = 18,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned LIFE_EASY  = 200,
    parameter int unsigned LIFE_MED   = 100,
    parameter int unsigned LIFE_HARD  = 50,
    parameter int unsigned MAX_ACTIVE = 4
) (
    input logic              clk,
    input logic              rst,
    mole_led_timer_if.slave  bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0]       presc_q, presc_d;
    logic [NUM_LEDS-1:0] led_on_q, led_on_d;
    logic [NUM_LEDS-1:0] expired_q, expired_d;
    logic [7:0]          timer_q [NUM_LEDS];
    logic [7:0]          timer_d [NUM_LEDS];
    logic                req_drop_q, req_drop_d;
    logic [5:0]          active_cnt_q, active_cnt_d;
    logic                tick;
    logic                idx_ok, idx_lit, accept;
    logic [7:0]          life;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        unique case (bus.level)
            2'd0:    life = 8'(LIFE_EASY);
            2'd1:    life = 8'(LIFE_MED);
            default: life = 8'(LIFE_HARD);
        endcase
    end

    // Acceptance looks only at pre-update state, so a lit LED being cleared this cycle still drops.
    always_comb begin
        idx_ok  = 1'b0;
        idx_lit = 1'b0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            if (bus.led_index == 5'(i)) begin
                idx_ok  = 1'b1;
                idx_lit = led_on_q[i];
            end
        end
        accept = bus.led_request && idx_ok && !idx_lit
                 && ({26'd0, active_cnt_q} < MAX_ACTIVE);
    end

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        led_on_d   = led_on_q;
        timer_d    = timer_q;
        expired_d  = '0;
        req_drop_d = bus.led_request && !accept;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            if (led_on_q[i]) begin
                if (bus.hit_clear[i]) begin
                    led_on_d[i] = 1'b0;
                    timer_d[i]  = '0;
                end else if (tick) begin
                    if (timer_q[i] <= 8'd1) begin
                        led_on_d[i]  = 1'b0;
                        timer_d[i]   = '0;
                        expired_d[i] = 1'b1;
                    end else begin
                        timer_d[i] = timer_q[i] - 8'd1;
                    end
                end
            end else if (accept && bus.led_index == 5'(i)) begin
                led_on_d[i] = 1'b1;
                timer_d[i]  = life;
            end
        end
        active_cnt_d = '0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            active_cnt_d = active_cnt_d + {5'd0, led_on_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            led_on_q     <= '0;
            expired_q    <= '0;
            req_drop_q   <= 1'b0;
            active_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                timer_q[i] <= '0;
            end
        end else begin
            presc_q      <= presc_d;
            led_on_q     <= led_on_d;
            expired_q    <= expired_d;
            req_drop_q   <= req_drop_d;
            active_cnt_q <= active_cnt_d;
            timer_q      <= timer_d;
        end
    end

    assign bus.led_on     = led_on_q;
    assign bus.expired    = expired_q;
    assign bus.req_drop   = req_drop_q;
    assign bus.active_cnt = active_cnt_q;

`ifdef MOLE_MISS_CNT_EN
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic [5:0] exp_pop;
    logic [8:0] miss_sum;

    always_comb begin
        exp_pop = '0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            exp_pop = exp_pop + {5'd0, expired_d[i]};
        end
        miss_sum   = {1'b0, miss_cnt_q} + {3'd0, exp_pop};
        miss_cnt_d = miss_sum[8] ? 8'hff : miss_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_mole_led_timer.sv
// Scoreboard bench for mole_led_timer: a behavioural model queues the expected registered outputs
// for each clock edge, which are popped and compared one cycle later; directed scenarios then random.
module tb_mole_led_timer;
    localparam int NL = 18;
    localparam int TD = 4;
    localparam int MA = 2;

    typedef struct {
        logic [NL-1:0] on;
        logic [NL-1:0] ex;
        logic          drop;
        int            cnt;
        int            miss;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_mis = 0;

    bit   m_on  [NL];
    int   m_tmr [NL];
    int   m_presc = 0;
    int   m_miss  = 0;
    exp_t sb [$];

    mole_led_timer_if #(.NUM_LEDS(NL)) bus ();

    mole_led_timer #(
        .NUM_LEDS  (NL),
        .TICK_DIV  (TD),
        .LIFE_EASY (3),
        .LIFE_MED  (2),
        .LIFE_HARD (1),
        .MAX_ACTIVE(MA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int life_of(input logic [1:0] lvl);
        if (lvl == 2'd0) return 3;
        if (lvl == 2'd1) return 2;
        return 1;
    endfunction

    function automatic int model_lit();
        int n = 0;
        for (int i = 0; i < NL; i++) n += int'(m_on[i]);
        return n;
    endfunction

    // Advance the model by one edge, queue its prediction, clock the DUT, then compare.
    task automatic step();
        exp_t e;
        int   idx;
        bit   ok;
        bit   tick;
        e.on = '0; e.ex = '0; e.drop = 1'b0; e.cnt = 0; e.miss = 0;
        if (rst) begin
            for (int i = 0; i < NL; i++) begin
                m_on[i]  = 1'b0;
                m_tmr[i] = 0;
            end
            m_presc = 0;
            m_miss  = 0;
        end else begin
            idx = int'(bus.led_index);
            ok  = bus.led_request && (idx < NL) && (model_lit() < MA);
            if (ok) ok = !m_on[idx];
            tick    = (m_presc == TD - 1);
            m_presc = tick ? 0 : m_presc + 1;
            for (int i = 0; i < NL; i++) begin
                if (m_on[i]) begin
                    if (bus.hit_clear[i]) begin
                        m_on[i]  = 1'b0;
                        m_tmr[i] = 0;
                    end else if (tick) begin
                        if (m_tmr[i] == 1) begin
                            m_on[i]  = 1'b0;
                            m_tmr[i] = 0;
                            e.ex[i]  = 1'b1;
                        end else begin
                            m_tmr[i]--;
                        end
                    end
                end
            end
            if (ok) begin
                m_on[idx]  = 1'b1;
                m_tmr[idx] = life_of(bus.level);
            end
            e.drop = bus.led_request && !ok;
            for (int i = 0; i < NL; i++) begin
                e.on[i] = m_on[i];
                m_miss += int'(e.ex[i]);
            end
            if (m_miss > 255) m_miss = 255;
            e.cnt  = model_lit();
            e.miss = m_miss;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("led_on",     32'(bus.led_on),     32'(e.on));
        chk("expired",    32'(bus.expired),    32'(e.ex));
        chk("req_drop",   32'(bus.req_drop),   32'(e.drop));
        chk("active_cnt", 32'(bus.active_cnt), 32'(e.cnt));
`ifdef MOLE_MISS_CNT_EN
        chk("miss_cnt",   32'(bus.miss_cnt),   32'(e.miss));
`endif
    endtask

    task automatic idle(input int n);
        bus.led_request = 1'b0;
        bus.hit_clear   = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic request(input int idx, input int lvl);
        bus.led_index   = 5'(idx);
        bus.level       = 2'(lvl);
        bus.led_request = 1'b1;
        step();
        bus.led_request = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && model_lit() != 0; i++) idle(1);
        chk("drain", 32'(bus.active_cnt), 32'd0);
    endtask

    // Step until the next edge is a tick edge.
    task automatic to_tick_edge();
        for (int i = 0; i < TD && m_presc != TD - 1; i++) idle(1);
    endtask

    initial begin
        int n;
        bus.level       = 2'd0;
        bus.led_index   = 5'd0;
        bus.led_request = 1'b0;
        bus.hit_clear   = '0;

        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Lifetime at level 0.
        request(5, 0);
        chk("life_lit", 32'(bus.led_on[5]), 32'd1);
        n = 0;
        while (bus.expired[5] !== 1'b1 && n < 30) begin
            idle(1);
            n++;
        end
        chk("life_exp_seen", 32'(bus.expired[5]), 32'd1);
        chk("life_off", 32'(bus.led_on[5]), 32'd0);
        drain();

        // Hit before timeout.
        request(0, 1);
        chk("hit_cnt1", 32'(bus.active_cnt), 32'd1);
        bus.hit_clear = NL'(1);
        step();
        bus.hit_clear = '0;
        chk("hit_off", 32'(bus.led_on[0]), 32'd0);
        chk("hit_noexp", 32'(bus.expired[0]), 32'd0);
        chk("hit_cnt0", 32'(bus.active_cnt), 32'd0);

        // Bad index.
        request(18, 0);
        chk("bad_drop", 32'(bus.req_drop), 32'd1);
        chk("bad_leds", 32'(bus.led_on), 32'd0);
        idle(1);
        chk("bad_drop_1cyc", 32'(bus.req_drop), 32'd0);

        // Re-request of a lit LED.
        request(3, 0);
        idle(2);
        request(3, 0);
        chk("lit_drop", 32'(bus.req_drop), 32'd1);
        drain();

        // Cap at MAX_ACTIVE, then reuse of the freed slot.
        request(1, 2);
        request(2, 0);
        request(7, 0);
        chk("cap_drop", 32'(bus.req_drop), 32'd1);
        chk("cap_cnt", 32'(bus.active_cnt), 32'd2);
        for (int i = 0; i < 20 && m_on[1]; i++) idle(1);
        request(7, 0);
        chk("cap_reuse", 32'(bus.led_on[7]), 32'd1);
        drain();

        // Hit on the same cycle as the final tick: clear wins.
        to_tick_edge();
        idle(1);
        request(4, 2);
        to_tick_edge();
        bus.hit_clear = NL'(1) << 4;
        step();
        bus.hit_clear = '0;
        chk("tie_noexp", 32'(bus.expired[4]), 32'd0);
        chk("tie_off", 32'(bus.led_on[4]), 32'd0);

        // Two LEDs expiring on the same tick.
        to_tick_edge();
        idle(1);
        request(8, 2);
        request(9, 2);
        n = 0;
        while (bus.expired === '0 && n < 8) begin
            idle(1);
            n++;
        end
        chk("dual_exp", 32'(bus.expired), 32'h300);
        drain();

        // Reset mid-operation.
        request(10, 0);
        request(11, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_clear", 32'(bus.led_on), 32'd0);

        // Random traffic, including out-of-range indices and sparse hits.
        for (int i = 0; i < 300; i++) begin
            bus.led_request = ($urandom_range(0, 2) == 0);
            bus.led_index   = 5'($urandom_range(0, 20));
            bus.level       = 2'($urandom_range(0, 3));
            bus.hit_clear   = NL'($urandom & $urandom & $urandom);
            step();
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
